// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: source identifiers, the result
// request bundle and default widths.
package wb_arbiter_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = 5;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MDU  = 2'd2,
    WB_LSU  = 2'd3
  } wb_src_e;

  typedef struct packed {
    logic                valid;
    logic [AW_DEF-1:0]   rd;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;

  // The round-robin pointer only ever names one of the two long-latency sources.
  function automatic wb_src_e rr_other(input wb_src_e s);
    return (s == WB_MDU) ? WB_LSU : WB_MDU;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of producer results, issue/decode checks and register-file write
// signals around the writeback arbiter.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF
) ();

  // Handshake: a producer raises *_valid with rd/data and holds all three
  // stable until it sees *_ready; a transfer happens on the cycle where both
  // are high. The ALU has no ready and is always taken when valid.
  logic             alu_valid;
  logic [AW-1:0]    alu_rd;
  logic [XLEN-1:0]  alu_data;
  logic             mdu_valid;
  logic             mdu_ready;
  logic [AW-1:0]    mdu_rd;
  logic [XLEN-1:0]  mdu_data;
  logic             lsu_valid;
  logic             lsu_ready;
  logic [AW-1:0]    lsu_rd;
  logic [XLEN-1:0]  lsu_data;
  logic             iss_valid;
  logic [AW-1:0]    iss_rd;
  logic [AW-1:0]    chk_rs1;
  logic [AW-1:0]    chk_rs2;
  logic [AW-1:0]    chk_rd;
  logic             hazard;
  logic             rf_we;
  logic [AW-1:0]    rf_rd;
  logic [XLEN-1:0]  rf_wd;
  logic [NREGS-1:0] busy_mask;
  wb_src_e          dbg_rr_ptr;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mdu_valid, mdu_rd, mdu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd, chk_rs1, chk_rs2, chk_rd,
    output mdu_ready, lsu_ready, hazard,
    output rf_we, rf_rd, rf_wd, busy_mask, dbg_rr_ptr
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mdu_valid, mdu_rd, mdu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd, chk_rs1, chk_rs2, chk_rd,
    input  mdu_ready, lsu_ready, hazard,
    input  rf_we, rf_rd, rf_wd, busy_mask, dbg_rr_ptr
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Busy bits for registers awaiting a long-latency result, and the decode
// hazard compare against them.
module wb_scoreboard
  import wb_arbiter_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_valid,
  input  logic [AW-1:0]    set_rd,
  input  logic             clr_valid,
  input  logic [AW-1:0]    clr_rd,
  input  logic [AW-1:0]    chk_rs1,
  input  logic [AW-1:0]    chk_rs2,
  input  logic [AW-1:0]    chk_rd,
  output logic             hazard,
  output logic [NREGS-1:0] busy_mask
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] set_vec, clr_vec;

  // Set is applied after clear so a reissue at the retire edge stays pending.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_valid && (set_rd != '0)) set_vec[set_rd] = 1'b1;
    if (clr_valid) clr_vec[clr_rd] = 1'b1;
    busy_d = (busy_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign hazard = ((chk_rs1 != '0) && busy_q[chk_rs1])
                | ((chk_rs2 != '0) && busy_q[chk_rs2])
                | ((chk_rd  != '0) && busy_q[chk_rd]);

  assign busy_mask = busy_q;

endmodule

// File: rtl/wb_arbiter.sv
// Drives the register file's single write port from the ALU, MDU and LSU,
// ALU first, with round-robin between the two long-latency producers.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic       clk,
  input  logic       rst,
  wb_arbiter_if.slave bus
);

  wb_req_t         alu_req, mdu_req, lsu_req, sel_req;
  wb_src_e         grant;
  wb_src_e         ptr_q, ptr_d;
  logic            contested;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;

  assign alu_req = '{valid: bus.alu_valid, rd: bus.alu_rd, data: bus.alu_data};
  assign mdu_req = '{valid: bus.mdu_valid, rd: bus.mdu_rd, data: bus.mdu_data};
  assign lsu_req = '{valid: bus.lsu_valid, rd: bus.lsu_rd, data: bus.lsu_data};

  always_comb begin
    contested = bus.mdu_valid && bus.lsu_valid;
    grant     = WB_NONE;
    if (rst)                grant = WB_NONE;
    else if (bus.alu_valid) grant = WB_ALU;
    else if (contested)     grant = ptr_q;
    else if (bus.mdu_valid) grant = WB_MDU;
    else if (bus.lsu_valid) grant = WB_LSU;
  end

  always_comb begin
    case (grant)
      WB_ALU:  sel_req = alu_req;
      WB_MDU:  sel_req = mdu_req;
      WB_LSU:  sel_req = lsu_req;
      default: sel_req = '0;
    endcase
    ptr_d = (contested && (grant != WB_NONE) && (grant != WB_ALU)) ? rr_other(ptr_q) : ptr_q;
    // A write to x0 completes the handshake but never strobes the port.
    rf_we_d = sel_req.valid && (sel_req.rd != '0);
    rf_rd_d = rf_we_d ? sel_req.rd   : rf_rd_q;
    rf_wd_d = rf_we_d ? sel_req.data : rf_wd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= WB_MDU;
      rf_we_q <= 1'b0;
      rf_rd_q <= '0;
      rf_wd_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      rf_we_q <= rf_we_d;
      rf_rd_q <= rf_rd_d;
      rf_wd_q <= rf_wd_d;
    end
  end

  wb_scoreboard #(.NREGS(NREGS), .AW(AW)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_valid (bus.iss_valid),
    .set_rd    (bus.iss_rd),
    .clr_valid ((grant == WB_MDU) || (grant == WB_LSU)),
    .clr_rd    (sel_req.rd),
    .chk_rs1   (bus.chk_rs1),
    .chk_rs2   (bus.chk_rs2),
    .chk_rd    (bus.chk_rd),
    .hazard    (bus.hazard),
    .busy_mask (bus.busy_mask)
  );

  assign bus.mdu_ready  = (grant == WB_MDU);
  assign bus.lsu_ready  = (grant == WB_LSU);
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_rd      = rf_rd_q;
  assign bus.rf_wd      = rf_wd_q;
  assign bus.dbg_rr_ptr = ptr_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a priority-list model of the arbiter and
// scoreboard checked every cycle, plus hand-computed literal checkpoints.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic clk;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  wb_arbiter_if #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) bus ();

  wb_arbiter #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mdu_valid = 1'b0; bus.mdu_rd = '0; bus.mdu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0; bus.lsu_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.chk_rs1 = '0; bus.chk_rs2 = '0; bus.chk_rd = '0;
  endtask

  task automatic drive_alu(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    bus.alu_valid = 1'b1; bus.alu_rd = rd; bus.alu_data = d;
  endtask

  task automatic drive_mdu(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    bus.mdu_valid = 1'b1; bus.mdu_rd = rd; bus.mdu_data = d;
  endtask

  task automatic drive_lsu(input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    bus.lsu_valid = 1'b1; bus.lsu_rd = rd; bus.lsu_data = d;
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    bus.iss_valid = 1'b1; bus.iss_rd = rd;
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  logic [AW+XLEN-1:0] exp_q[$];
  bit                 busy_m [NREGS];
  bit                 owner_lsu = 1'b0;
  bit                 hold_known = 1'b1;
  logic [AW-1:0]      held_rd = '0;
  logic [XLEN-1:0]    held_wd = '0;

  function automatic bit req_of(input wb_src_e s);
    case (s)
      WB_ALU:  return bus.alu_valid;
      WB_MDU:  return bus.mdu_valid;
      WB_LSU:  return bus.lsu_valid;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [AW-1:0] rd_of(input wb_src_e s);
    case (s)
      WB_ALU:  return bus.alu_rd;
      WB_MDU:  return bus.mdu_rd;
      default: return bus.lsu_rd;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] data_of(input wb_src_e s);
    case (s)
      WB_ALU:  return bus.alu_data;
      WB_MDU:  return bus.mdu_data;
      default: return bus.lsu_data;
    endcase
  endfunction

  function automatic bit pending(input logic [AW-1:0] r);
    return (r != '0) && busy_m[r];
  endfunction

  initial begin
    wb_src_e            order [3];
    wb_src_e            win;
    logic [AW+XLEN-1:0] e;
    logic [NREGS-1:0]   bm;
    logic [AW-1:0]      w_rd;
    for (int i = 0; i < NREGS; i++) busy_m[i] = 1'b0;
    forever begin
      @(negedge clk);
      // registered outputs reflect the previous edge
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rf_we", bus.rf_we, 1);
        chk("rf_rd", bus.rf_rd, e[AW+XLEN-1:XLEN]);
        chk("rf_wd", bus.rf_wd, e[XLEN-1:0]);
      end else begin
        chk("rf_we_idle", bus.rf_we, 0);
        if (hold_known) begin
          chk("rf_rd_hold", bus.rf_rd, held_rd);
          chk("rf_wd_hold", bus.rf_wd, held_wd);
        end
      end
      for (int i = 0; i < NREGS; i++) bm[i] = busy_m[i];
      chk("busy_mask", bus.busy_mask, bm);
      chk("rr_ptr", bus.dbg_rr_ptr, owner_lsu ? WB_LSU : WB_MDU);

      // who wins this cycle: first requester in priority order
      order[0] = WB_ALU;
      order[1] = owner_lsu ? WB_LSU : WB_MDU;
      order[2] = owner_lsu ? WB_MDU : WB_LSU;
      win = WB_NONE;
      if (!rst)
        for (int k = 0; k < 3; k++)
          if (win == WB_NONE && req_of(order[k])) win = order[k];

      chk("mdu_ready", bus.mdu_ready, win == WB_MDU);
      chk("lsu_ready", bus.lsu_ready, win == WB_LSU);
      chk("hazard", bus.hazard,
          pending(bus.chk_rs1) || pending(bus.chk_rs2) || pending(bus.chk_rd));
      if (!rst && bus.alu_valid) chk("alu_target_free", bus.busy_mask[bus.alu_rd], 0);

      // advance the model across the coming edge
      if (rst) begin
        for (int i = 0; i < NREGS; i++) busy_m[i] = 1'b0;
        owner_lsu  = 1'b0;
        hold_known = 1'b1;
        held_rd    = '0;
        held_wd    = '0;
        exp_q.delete();
      end else begin
        if (win != WB_NONE) begin
          w_rd = rd_of(win);
          if (w_rd != '0) begin
            exp_q.push_back({w_rd, data_of(win)});
            held_rd    = w_rd;
            held_wd    = data_of(win);
            hold_known = 1'b1;
          end else begin
            hold_known = 1'b0;
          end
          if (win != WB_ALU) busy_m[w_rd] = 1'b0;
          if (win != WB_ALU && bus.mdu_valid && bus.lsu_valid) owner_lsu = !owner_lsu;
        end
        if (bus.iss_valid && bus.iss_rd != '0) busy_m[bus.iss_rd] = 1'b1;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #50000;
    n_err++;
    $display("FAIL watchdog: bench did not reach its end by %0t", $time);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    idle_all();
    drive_alu(1, 32'h1); drive_mdu(2, 32'h2); drive_lsu(3, 32'h3); issue(3);
    #1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_rf_we", bus.rf_we, 0);
      chk("rst_busy", bus.busy_mask, 0);
      chk("rst_mdu_ready", bus.mdu_ready, 0);
      chk("rst_lsu_ready", bus.lsu_ready, 0);
    end
    rst = 1'b0;
    idle_all();
    tick();

    // ALU beats a waiting MDU result
    drive_alu(5, 32'h11); drive_mdu(6, 32'h22);
    #1 chk("prio_mdu_ready", bus.mdu_ready, 0);
    tick();
    bus.alu_valid = 1'b0;
    chk("prio_we", bus.rf_we, 1); chk("prio_rd", bus.rf_rd, 5); chk("prio_wd", bus.rf_wd, 32'h11);
    #1 chk("prio_mdu_ready2", bus.mdu_ready, 1);
    tick();
    bus.mdu_valid = 1'b0;
    chk("prio_mdu_rd", bus.rf_rd, 6); chk("prio_mdu_wd", bus.rf_wd, 32'h22);
    tick();
    chk("prio_idle_we", bus.rf_we, 0); chk("prio_idle_rd", bus.rf_rd, 6);

    // Round robin: contested twice, pointer ends back on MDU
    drive_mdu(7, 32'hA); drive_lsu(8, 32'hB);
    #1 chk("rr_mdu_first", bus.mdu_ready, 1);
    tick();
    drive_mdu(10, 32'hC);
    chk("rr_rd7", bus.rf_rd, 7); chk("rr_wdA", bus.rf_wd, 32'hA); chk("rr_ptr_lsu", bus.dbg_rr_ptr, WB_LSU);
    #1 chk("rr_lsu_second", bus.lsu_ready, 1);
    tick();
    bus.lsu_valid = 1'b0;
    chk("rr_rd8", bus.rf_rd, 8); chk("rr_wdB", bus.rf_wd, 32'hB); chk("rr_ptr_mdu", bus.dbg_rr_ptr, WB_MDU);
    tick();
    bus.mdu_valid = 1'b0;
    chk("rr_rd10", bus.rf_rd, 10); chk("rr_wdC", bus.rf_wd, 32'hC);

    // ALU cycle with both long-latency sources waiting leaves the pointer alone
    drive_alu(11, 32'h5); drive_mdu(13, 32'hD); drive_lsu(14, 32'hE);
    tick();
    bus.alu_valid = 1'b0;
    chk("alu3_rd", bus.rf_rd, 11); chk("alu3_ptr", bus.dbg_rr_ptr, WB_MDU);
    tick();
    bus.mdu_valid = 1'b0;
    chk("alu3_mdu_rd", bus.rf_rd, 13); chk("alu3_ptr2", bus.dbg_rr_ptr, WB_LSU);
    tick();
    bus.lsu_valid = 1'b0;
    chk("alu3_lsu_rd", bus.rf_rd, 14);

    // Scoreboard: rd 9 pending until its load retires
    issue(9);
    tick();
    bus.iss_valid = 1'b0;
    chk("sb_busy9", bus.busy_mask, 32'h0000_0200);
    bus.chk_rs1 = 9;
    #1 chk("sb_haz_rs1", bus.hazard, 1);
    tick();
    drive_lsu(9, 32'h99);
    #1 chk("sb_haz_hold", bus.hazard, 1);
    tick();
    bus.lsu_valid = 1'b0;
    chk("sb_haz_clear", bus.hazard, 0); chk("sb_we9", bus.rf_we, 1);
    chk("sb_rd9", bus.rf_rd, 9); chk("sb_busy_clear", bus.busy_mask, 0);
    bus.chk_rs1 = '0;

    // rs2 and rd (WAW) terms
    issue(12);
    tick();
    bus.iss_valid = 1'b0;
    bus.chk_rs2 = 12;
    #1 chk("sb_haz_rs2", bus.hazard, 1);
    bus.chk_rs2 = '0; bus.chk_rd = 12;
    #1 chk("sb_haz_waw", bus.hazard, 1);
    bus.chk_rd = 11;
    #1 chk("sb_haz_other", bus.hazard, 0);
    drive_mdu(12, 32'h12);
    tick();
    bus.mdu_valid = 1'b0; bus.chk_rd = 12;
    #1 chk("sb_haz_waw_clear", bus.hazard, 0);
    bus.chk_rd = '0;

    // Set beats clear on the same register
    issue(4);
    tick();
    drive_mdu(4, 32'h44);
    tick();
    bus.mdu_valid = 1'b0; bus.iss_valid = 1'b0;
    chk("sbc_busy4", bus.busy_mask[4], 1); chk("sbc_we", bus.rf_we, 1);
    chk("sbc_rd", bus.rf_rd, 4); chk("sbc_wd", bus.rf_wd, 32'h44);
    drive_mdu(4, 32'h45);
    tick();
    bus.mdu_valid = 1'b0;
    chk("sbc_busy_clear", bus.busy_mask, 0);

    // x0: handshake completes, nothing written or tracked
    drive_lsu(0, 32'hFFFF);
    #1 chk("x0_lsu_ready", bus.lsu_ready, 1);
    tick();
    bus.lsu_valid = 1'b0;
    chk("x0_no_we", bus.rf_we, 0);
    issue(0);
    tick();
    bus.iss_valid = 1'b0;
    chk("x0_no_busy", bus.busy_mask, 0);
    bus.chk_rs1 = '0;
    #1 chk("x0_no_hazard", bus.hazard, 0);

    // Reset mid-operation: pending bit, pointer and contested grant are dropped
    issue(15);
    tick();
    bus.iss_valid = 1'b0;
    drive_mdu(15, 32'h77); drive_lsu(16, 32'h78);
    rst = 1'b1;
    #1 chk("mid_rst_mdu_ready", bus.mdu_ready, 0); chk("mid_rst_lsu_ready", bus.lsu_ready, 0);
    tick();
    chk("mid_rst_busy", bus.busy_mask, 0); chk("mid_rst_we", bus.rf_we, 0);
    chk("mid_rst_ptr", bus.dbg_rr_ptr, WB_MDU);
    rst = 1'b0;
    #1 chk("post_rst_mdu_ready", bus.mdu_ready, 1);
    tick();
    bus.mdu_valid = 1'b0;
    chk("post_rst_rd", bus.rf_rd, 15); chk("post_rst_wd", bus.rf_wd, 32'h77);
    tick();
    bus.lsu_valid = 1'b0;
    chk("post_rst_rd16", bus.rf_rd, 16);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback-side driver of the register file's single write port.
- Merges results from the single-cycle ALU pipe with two long-latency producers (multiply/divide unit, load/store unit) and arbitrates them onto one write per cycle.
- Holds a busy scoreboard of registers with outstanding long-latency writes, and raises a hazard to decode so operands are never read stale.

Parameters:
- XLEN, 32, data width of results and write data
- NREGS, 32, number of architectural registers
- AW, 5, register address width (clog2 of NREGS)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result present this cycle; no backpressure
- alu_rd  in  AW  ALU destination
- alu_data  in  XLEN  ALU result
- mdu_valid  in  1  MDU result request
- mdu_ready  out  1  MDU result accepted this cycle
- mdu_rd  in  AW  MDU destination
- mdu_data  in  XLEN  MDU result
- lsu_valid  in  1  load result request
- lsu_ready  out  1  load result accepted this cycle
- lsu_rd  in  AW  load destination
- lsu_data  in  XLEN  load result
- iss_valid  in  1  long-latency op issued this cycle
- iss_rd  in  AW  destination of issued long-latency op
- chk_rs1  in  AW  decode source 1
- chk_rs2  in  AW  decode source 2
- chk_rd  in  AW  decode destination
- hazard  out  1  decode must stall
- rf_we  out  1  register file write enable
- rf_rd  out  AW  register file write address
- rf_wd  out  XLEN  register file write data
- busy_mask  out  NREGS  scoreboard state, bit i = register i pending

Behaviour:
- Reset values: rf_we=0, rf_rd=0, rf_wd=0, busy_mask=0, round-robin pointer=MDU.
- Reset mid-operation drops any in-flight grant and clears all busy bits; mdu_ready and lsu_ready are 0 while rst is high.
- Latency: an accepted result appears on rf_we/rf_rd/rf_wd exactly one cycle after acceptance. These outputs are registered.
- One write per cycle. When no source is accepted, rf_we=0 next cycle; rf_rd and rf_wd hold their previous values.
- Priority: alu_valid always wins. When alu_valid=1, mdu_ready=0 and lsu_ready=0.
- Secondary arbitration, when alu_valid=0:
  - only one of mdu_valid/lsu_valid high: that source is granted.
  - both high: the round-robin pointer's source is granted, and the pointer flips to the other source.
  - The pointer changes only on a contested grant.
- Ready signals are combinational from the valids and the pointer. A transfer occurs on valid&&ready.
- Sources hold valid, rd and data stable until ready; the arbiter never accepts a source whose valid is low.
- Writes to x0: the handshake completes normally, but rf_we stays 0 the next cycle.
- Scoreboard:
  - set busy[iss_rd] at the edge where iss_valid=1 and iss_rd!=0.
  - clear busy[rd] at the edge where an MDU or LSU result for that rd is accepted.
  - Clear timing aligns with rf_we rising, so the register file's same-cycle forwarding supplies the value.
  - Set and clear of the same register at the same edge: set wins (new op supersedes).
  - ALU writes never touch the scoreboard.
- hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd], with any index equal to 0 masked out. The chk_rd term covers WAW.
- Protocol rule: decode never lets an ALU op target a busy register. The bench asserts alu_valid implies !busy[alu_rd].
- Only one outstanding long-latency op per destination; reissue to a busy rd is prevented by hazard.

Decomposition:
- Shared package holds:
  - XLEN/AW/NREGS defaults.
  - a wb_src enum {WB_NONE, WB_ALU, WB_MDU, WB_LSU}.
  - a packed wb_req struct {valid, rd, data}.
- Sub-module: wb_scoreboard, containing the busy register, set/clear logic and hazard compare.
- Arbiter, pointer and output register stay in wb_arbiter.

Test Plan:
- Reset: assert rst 2 cycles with all valids high -> rf_we=0, busy_mask=0, mdu_ready=lsu_ready=0 throughout.
- ALU priority: alu_valid=1 rd=5 data=0x11, mdu_valid=1 rd=6 data=0x22 in the same cycle:
  - next cycle: rf_we=1, rf_rd=5, rf_wd=0x11, mdu_ready=0.
  - following cycle: MDU accepted, then rf_rd=6, rf_wd=0x22.
- Round-robin: mdu(rd=7, 0xA) and lsu(rd=8, 0xB) both valid for 2 cycles from reset -> writes rd=7 then rd=8 on consecutive cycles, pointer back at MDU.
- Scoreboard/hazard: iss_valid rd=9, then chk_rs1=9 -> hazard=1 until the lsu rd=9 acceptance edge; hazard=0 in the same cycle rf_we=1, rf_rd=9.
- Set-beats-clear: mdu result rd=4 accepted at the same edge as iss_valid rd=4 -> busy_mask[4] stays 1 and rf_we pulses for rd=4.
- x0 handling: lsu_valid rd=0 data=0xFFFF -> lsu_ready=1, rf_we stays 0; iss_valid rd=0 -> busy_mask unchanged; chk_rs1=0 -> hazard=0.
